// File: rtl/systolic_gemm_tile_if.sv
// rtl/systolic_gemm_tile_if.sv - operand and result stream bundle for systolic_gemm_tile
interface systolic_gemm_tile_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [ROWS-1:0][DATA_W-1:0]  a_col;
  logic [COLS-1:0][DATA_W-1:0]  b_row;
  logic                         out_valid;
  logic                         out_ready;
  logic [COLS-1:0][OUT_W-1:0]   out_row;
  logic [IDX_W-1:0]             out_row_idx;

  modport master (
    output in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx
  );

  modport slave (
    input  in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_row_idx
  );
endinterface

// File: rtl/systolic_gemm_tile.sv
// rtl/systolic_gemm_tile.sv - output-stationary GEMM tile; SYSTOLIC_SAT_EN selects saturating requantisation
module systolic_gemm_tile #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int K_MAX  = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [$clog2(K_MAX+1)-1:0] i_k_len,
  input  logic [4:0]                 i_cfg_shift,
  output logic                       o_busy,
  output logic                       o_done,
  systolic_gemm_tile_if.slave        bus
);
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int FW    = $clog2(ROWS + COLS);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

  state_t                     r_state;
  logic [KW-1:0]              r_k_len;
  logic [KW-1:0]              r_beat_cnt;
  logic [4:0]                 r_shift;
  logic [FW-1:0]              r_flush_cnt;
  logic [IDX_W-1:0]           r_row_idx;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [COLS-1:0][OUT_W-1:0] r_out_row;

  // Skew chains: row r / column c use stages 0..r / 0..c; the last used stage feeds the grid edge.
  logic signed [DATA_W-1:0]   r_a_sk [ROWS][ROWS];
  logic signed [DATA_W-1:0]   r_b_sk [COLS][COLS];
  logic signed [DATA_W-1:0]   r_pe_a [ROWS][COLS];
  logic signed [DATA_W-1:0]   r_pe_b [ROWS][COLS];
  logic signed [ACC_W-1:0]    r_acc  [ROWS][COLS];

  logic signed [DATA_W-1:0]   w_a_feed [ROWS];
  logic signed [DATA_W-1:0]   w_b_feed [COLS];
  logic signed [DATA_W-1:0]   w_a_in   [ROWS][COLS];
  logic signed [DATA_W-1:0]   w_b_in   [ROWS][COLS];
  logic signed [2*DATA_W-1:0] w_prod   [ROWS][COLS];
  logic [COLS-1:0][OUT_W-1:0] w_drain_row;
  logic [IDX_W-1:0]           w_sel;
  logic [KW-1:0]              w_k_clamped;
  logic                       w_accept;
  logic                       w_adv;
  logic                       w_clear;
  logic                       w_last_row;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_adv       = (r_state == S_FEED) || (r_state == S_FLUSH);
  assign w_clear     = (r_state == S_IDLE) && i_start;
  assign w_last_row  = (r_row_idx == IDX_W'(ROWS - 1));
  assign w_k_clamped = (i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : i_k_len;
  // The first drain cycle loads the current row; after that each handshake loads the next one.
  assign w_sel       = (r_out_valid && !w_last_row) ? r_row_idx + IDX_W'(1) : r_row_idx;

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_row     = r_out_row;
  assign bus.out_row_idx = r_row_idx;

  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                               input logic [4:0] sh);
    logic signed [ACC_W-1:0] s;
    s = acc >>> sh;
`ifdef SYSTOLIC_SAT_EN
    if (s > $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}}))
      s = $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    else if (s < $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}}))
      s = $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
`endif
    return OUT_W'(s);
  endfunction

  // Beats that are not accepted enter the skew chains as zeros so bubbles add nothing.
  always_comb begin
    for (int r = 0; r < ROWS; r++) w_a_feed[r] = w_accept ? bus.a_col[r] : '0;
    for (int c = 0; c < COLS; c++) w_b_feed[c] = w_accept ? bus.b_row[c] : '0;
    for (int c = 0; c < COLS; c++) w_drain_row[c] = requant(r_acc[w_sel][c], r_shift);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign w_a_in[r][c] = r_a_sk[r][r];
      end else begin : g_a_int
        assign w_a_in[r][c] = r_pe_a[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign w_b_in[r][c] = r_b_sk[c][c];
      end else begin : g_b_int
        assign w_b_in[r][c] = r_pe_b[r-1][c];
      end
      assign w_prod[r][c] = (2*DATA_W)'(w_a_in[r][c]) * (2*DATA_W)'(w_b_in[r][c]);
    end
  end

  // Skew chains and PE grid: cleared on start, advanced in FEED/FLUSH, frozen otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || w_clear) begin
      for (int r = 0; r < ROWS; r++) for (int j = 0; j < ROWS; j++) r_a_sk[r][j] <= '0;
      for (int c = 0; c < COLS; c++) for (int j = 0; j < COLS; j++) r_b_sk[c][j] <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_pe_a[r][c] <= '0;
          r_pe_b[r][c] <= '0;
          r_acc[r][c]  <= '0;
        end
      end
    end else if (w_adv) begin
      for (int r = 0; r < ROWS; r++) begin
        r_a_sk[r][0] <= w_a_feed[r];
        for (int j = 1; j < ROWS; j++) r_a_sk[r][j] <= r_a_sk[r][j-1];
      end
      for (int c = 0; c < COLS; c++) begin
        r_b_sk[c][0] <= w_b_feed[c];
        for (int j = 1; j < COLS; j++) r_b_sk[c][j] <= r_b_sk[c][j-1];
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_pe_a[r][c] <= w_a_in[r][c];
          r_pe_b[r][c] <= w_b_in[r][c];
          r_acc[r][c]  <= r_acc[r][c] + ACC_W'(w_prod[r][c]);
        end
      end
    end
  end

  // Job sequencer: IDLE -> FEED -> FLUSH -> DRAIN -> IDLE, with all handshake outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_shift     <= '0;
      r_flush_cnt <= '0;
      r_row_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k_len     <= w_k_clamped;
            r_shift     <= i_cfg_shift;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_row_idx   <= '0;
            r_busy      <= 1'b1;
            if (w_k_clamped != '0) begin
              r_in_ready <= 1'b1;
              r_state    <= S_FEED;
            end else begin
              r_state    <= S_DRAIN;
            end
          end
        end
        S_FEED: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + KW'(1);
            if (r_beat_cnt + KW'(1) == r_k_len) begin
              r_in_ready <= 1'b0;
              r_state    <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + FW'(1);
          if (r_flush_cnt == FW'(ROWS + COLS - 2)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!r_out_valid) begin
            r_out_row   <= w_drain_row;
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            if (w_last_row) begin
              r_out_valid <= 1'b0;
              r_row_idx   <= '0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_row_idx   <= r_row_idx + IDX_W'(1);
              r_out_row   <= w_drain_row;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_gemm_tile.sv
// tb/tb_systolic_gemm_tile.sv - scoreboard testbench for systolic_gemm_tile
module tb_systolic_gemm_tile;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int K_MAX  = 256;
  localparam int KW     = $clog2(K_MAX + 1);

  typedef logic [COLS-1:0][OUT_W-1:0] row_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic [4:0]      cfg_shift = '0;
  logic            busy;
  logic            done;

  systolic_gemm_tile_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus();

  systolic_gemm_tile #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .K_MAX(K_MAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_len(k_len),
    .i_cfg_shift(cfg_shift), .o_busy(busy), .o_done(done), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  row_t exp_q[$];
  row_t obs_q[$];
  int   exp_idx_q[$];
  int   obs_idx_q[$];
  logic signed [DATA_W-1:0] a_m [ROWS][16];
  logic signed [DATA_W-1:0] b_m [16][COLS];

  task automatic push_expected(input int k, input int sh);
    for (int r = 0; r < ROWS; r++) begin
      row_t row;
      for (int c = 0; c < COLS; c++) begin
        longint s;
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] sv;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(a_m[r][kk]) * longint'(b_m[kk][c]);
        acc = s[ACC_W-1:0];
        sv  = acc >>> sh;
`ifdef SYSTOLIC_SAT_EN
        if (sv > 32767) sv = 32767;
        else if (sv < -32768) sv = -32768;
`endif
        row[c] = sv[OUT_W-1:0];
      end
      exp_q.push_back(row);
      exp_idx_q.push_back(r);
    end
  endtask

  task automatic set_const(input int av, input int bv);
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < 16; k++) a_m[r][k] = DATA_W'(av);
    for (int k = 0; k < 16; k++) for (int c = 0; c < COLS; c++) b_m[k][c] = DATA_W'(bv);
  endtask

  task automatic set_rand();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < 16; k++) a_m[r][k] = DATA_W'($urandom);
    for (int k = 0; k < 16; k++) for (int c = 0; c < COLS; c++) b_m[k][c] = DATA_W'($urandom);
  endtask

  task automatic start_job(input int k, input int sh);
    start = 1'b1;
    k_len = KW'(k);
    cfg_shift = 5'(sh);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int k, input bit bubbles, output int cycles, output bit timeout);
    int b;
    bit v;
    b = 0; cycles = 0; timeout = 0;
    while (b < k) begin
      v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      for (int r = 0; r < ROWS; r++) bus.a_col[r] = v ? a_m[r][b] : DATA_W'($urandom);
      for (int c = 0; c < COLS; c++) bus.b_row[c] = v ? b_m[b][c] : DATA_W'($urandom);
      if (v && bus.in_ready === 1'b1) b++;
      @(negedge clk);
      cycles++;
      if (cycles > 2000) begin timeout = 1; break; end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect_rows(input int stall, output int hold_bad, output int early_done,
                              output logic done_end, output logic busy_end, output bit timeout);
    row_t held;
    int   w;
    hold_bad = 0; early_done = 0; timeout = 0; done_end = 1'b0; busy_end = 1'b1;
    for (int n = 0; n < ROWS; n++) begin
      w = 0;
      while (bus.out_valid !== 1'b1) begin
        if (done === 1'b1) early_done++;
        @(negedge clk);
        w++;
        if (w > 2000) begin timeout = 1; return; end
      end
      held = bus.out_row;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (bus.out_row !== held || bus.out_valid !== 1'b1) hold_bad++;
      end
      obs_q.push_back(bus.out_row);
      obs_idx_q.push_back(int'(bus.out_row_idx));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (n < ROWS - 1 && done === 1'b1) early_done++;
    end
    done_end = done;
    busy_end = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bus.in_ready, bus.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, bus.in_ready, bus.out_valid});
    end
    checks++;
    if (bus.out_row !== '0 || bus.out_row_idx !== '0) begin
      errors++;
      $display("FAIL reset_row: got %h idx %0d expected 0 idx 0", bus.out_row, bus.out_row_idx);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_in_valid: in_ready %b busy %b expected 0 0", bus.in_ready, busy);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_identity();
    int cyc, lat, hb, ed;
    bit to_f, to_c;
    logic de, be;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < 16; k++) a_m[r][k] = (r == k) ? 16'sd1 : 16'sd0;
    for (int k = 0; k < 16; k++) for (int c = 0; c < COLS; c++) b_m[k][c] = DATA_W'(10 * k + c);
    push_expected(4, 0);
    start_job(4, 0);
    feed(4, 1'b0, cyc, to_f);
    lat = cyc;
    while (bus.out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (to_f || lat != 12) begin errors++; $display("FAIL identity_latency: got %0d expected 12", lat); end
    collect_rows(0, hb, ed, de, be, to_c);
    checks++;
    if (to_c || ed != 0 || de !== 1'b1 || be !== 1'b0) begin
      errors++;
      $display("FAIL identity_done: timeout %0d early %0d done %b busy %b expected 0 0 1 0", to_c, ed, de, be);
    end
    while (exp_q.size() > 0) begin
      row_t e, o;
      int ei, oi;
      e = exp_q.pop_front(); ei = exp_idx_q.pop_front();
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); oi = obs_idx_q.pop_front(); end
      else begin o = 'x; oi = -1; end
      checks++;
      if (o !== e || oi != ei) begin errors++; $display("FAIL identity_row: got %h idx %0d expected %h idx %0d", o, oi, e, ei); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL identity_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_stalls();
    int cyc, hb, ed;
    bit to_f, to_c;
    logic de, be;
    set_rand();
    push_expected(16, 5);
    start_job(16, 5);
    feed(16, 1'b1, cyc, to_f);
    collect_rows(3, hb, ed, de, be, to_c);
    checks++;
    if (to_f || to_c || hb != 0) begin
      errors++;
      $display("FAIL stall_hold: timeout %0d/%0d hold_violations %0d expected 0", to_f, to_c, hb);
    end
    checks++;
    if (ed != 0 || de !== 1'b1) begin errors++; $display("FAIL stall_done: early %0d done %b expected 0 1", ed, de); end
    while (exp_q.size() > 0) begin
      row_t e, o;
      int ei, oi;
      e = exp_q.pop_front(); ei = exp_idx_q.pop_front();
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); oi = obs_idx_q.pop_front(); end
      else begin o = 'x; oi = -1; end
      checks++;
      if (o !== e || oi != ei) begin errors++; $display("FAIL stall_row: got %h idx %0d expected %h idx %0d", o, oi, e, ei); end
    end
  endtask

  task automatic test_wrap_sat();
    int cyc, hb, ed;
    bit to_f, to_c;
    logic de, be;
    row_t er;
`ifdef SYSTOLIC_SAT_EN
    er = {COLS{16'h8000}};
`else
    er = {COLS{16'h0004}};
`endif
    set_const(16'h7FFF, 16'h7FFF);
    start_job(4, 0);
    feed(4, 1'b0, cyc, to_f);
    collect_rows(0, hb, ed, de, be, to_c);
    checks++;
    if (to_f || to_c || obs_q.size() != ROWS) begin
      errors++;
      $display("FAIL wrap_rows: timeout %0d/%0d rows %0d expected 0/0 %0d", to_f, to_c, obs_q.size(), ROWS);
    end
    while (obs_q.size() > 0) begin
      row_t o;
      int oi;
      o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
      checks++;
      if (o !== er) begin errors++; $display("FAIL wrap_value: row %0d got %h expected %h", oi, o, er); end
    end
  endtask

  task automatic test_shift();
    int cyc, hb, ed;
    bit to_f, to_c;
    logic de, be;
    row_t er;
    for (int job = 0; job < 2; job++) begin
      set_const(-3, (job == 0) ? -3 : 1);
      er = (job == 0) ? {COLS{16'h0009}} : {COLS{16'hFFFD}};
      start_job(2, 1);
      feed(2, 1'b0, cyc, to_f);
      collect_rows(0, hb, ed, de, be, to_c);
      checks++;
      if (to_f || to_c || obs_q.size() != ROWS) begin
        errors++;
        $display("FAIL shift_rows%0d: timeout %0d/%0d rows %0d expected %0d", job, to_f, to_c, obs_q.size(), ROWS);
      end
      while (obs_q.size() > 0) begin
        row_t o;
        int oi;
        o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
        checks++;
        if (o !== er) begin errors++; $display("FAIL shift_value%0d: row %0d got %h expected %h", job, oi, o, er); end
      end
    end
  endtask

  task automatic test_klen0();
    int hb, ed, w;
    bit to_c;
    logic de, be;
    start_job(0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL klen0_busy: got %b expected 1", busy); end
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    start_job(3, 0);
    collect_rows(0, hb, ed, de, be, to_c);
    checks++;
    if (to_c || ed != 0 || de !== 1'b1 || obs_q.size() != ROWS) begin
      errors++;
      $display("FAIL klen0_done: timeout %0d early %0d done %b rows %0d expected 0 0 1 %0d", to_c, ed, de, obs_q.size(), ROWS);
    end
    for (int n = 0; obs_q.size() > 0; n++) begin
      row_t o;
      int oi;
      o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
      checks++;
      if (o !== '0 || oi != n) begin errors++; $display("FAIL klen0_row: got %h idx %0d expected 0 idx %0d", o, oi, n); end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL klen0_start_ignored: busy %b out_valid %b expected 0 0", busy, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_feed();
    int cyc, hb, ed, b;
    bit to_f, to_c;
    logic de, be;
    set_rand();
    start_job(8, 0);
    b = 0;
    for (int n = 0; n < 20 && b < 5; n++) begin
      bus.in_valid = 1'b1;
      for (int r = 0; r < ROWS; r++) bus.a_col[r] = a_m[r][b];
      for (int c = 0; c < COLS; c++) bus.b_row[c] = b_m[b][c];
      if (bus.in_ready === 1'b1) b++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.in_ready, bus.out_valid} !== 4'b0000 || bus.out_row !== '0 || bus.out_row_idx !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: flags %b row %h idx %0d expected 0", {busy, done, bus.in_ready, bus.out_valid}, bus.out_row, bus.out_row_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_done: done %b busy %b expected 0 0", done, busy); end
    set_rand();
    push_expected(6, 2);
    start_job(6, 2);
    feed(6, 1'b0, cyc, to_f);
    collect_rows(1, hb, ed, de, be, to_c);
    checks++;
    if (to_f || to_c || hb != 0 || de !== 1'b1) begin
      errors++;
      $display("FAIL midreset_job: timeout %0d/%0d hold %0d done %b expected 0/0 0 1", to_f, to_c, hb, de);
    end
    while (exp_q.size() > 0) begin
      row_t e, o;
      int ei, oi;
      e = exp_q.pop_front(); ei = exp_idx_q.pop_front();
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); oi = obs_idx_q.pop_front(); end
      else begin o = 'x; oi = -1; end
      checks++;
      if (o !== e || oi != ei) begin errors++; $display("FAIL midreset_row: got %h idx %0d expected %h idx %0d", o, oi, e, ei); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, hb, ed;
    bit to_f, to_c;
    logic de, be;
    set_rand();
    push_expected(3, 3);
    start_job(3, 3);
    feed(3, 1'b0, cyc, to_f);
    collect_rows(0, hb, ed, de, be, to_c);
    checks++;
    if (to_f || to_c || de !== 1'b1 || be !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done: timeout %0d/%0d done %b busy %b expected 0/0 1 0", to_f, to_c, de, be);
    end
    set_rand();
    push_expected(2, 0);
    start_job(2, 0);
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start_in_done: busy %b in_ready %b expected 1 1", busy, bus.in_ready);
    end
    feed(2, 1'b0, cyc, to_f);
    collect_rows(0, hb, ed, de, be, to_c);
    checks++;
    if (to_f || to_c || de !== 1'b1) begin errors++; $display("FAIL b2b_second_done: timeout %0d/%0d done %b expected 0/0 1", to_f, to_c, de); end
    while (exp_q.size() > 0) begin
      row_t e, o;
      int ei, oi;
      e = exp_q.pop_front(); ei = exp_idx_q.pop_front();
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); oi = obs_idx_q.pop_front(); end
      else begin o = 'x; oi = -1; end
      checks++;
      if (o !== e || oi != ei) begin errors++; $display("FAIL b2b_row: got %h idx %0d expected %h idx %0d", o, oi, e, ei); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_col     = '0;
    bus.b_row     = '0;
    test_reset();
    test_identity();
    test_stalls();
    test_wrap_sat();
    test_shift();
    test_klen0();
    test_reset_mid_feed();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
